// File: rtl/mesh_term_inject.sv
// mesh_term_inject
// Terminal-side injection stage for one mesh_gnrtr terminal. Host writes are
// assembled into the mesh packet format and buffered in a first-word-fall-
// through queue. The queue head is presented to the mesh terminal, and the
// mesh retires it with popin. Writes with an illegal destination are dropped
// and counted. Writes into a full queue are also dropped and counted.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   wr_en                 host write strobe (one packet per cycle)
//   wr_row, wr_col        destination coordinates (4 bits each)
//   wr_mode               routing mode bit, carried into the packet
//   wr_bcast              broadcast; forces row/col to F/F, skips dest check
//   wr_payload            PCKG_SZ-17 bit payload
//   wr_ready              queue has a free entry (registered count only)
//   data_out_i_in         head packet (0 when empty), combinational read
//   pndng_i_in            queue non-empty
//   popin                 mesh consumed the head this cycle
//   occupancy             current entry count
//   ovf_cnt               saturating count of full-queue drops
//   bad_dest_cnt          saturating count of illegal-destination drops
module mesh_term_inject #(
  parameter int ROWS       = 4,
  parameter int COLUMS     = 4,
  parameter int PCKG_SZ    = 40,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              wr_en,
  input  logic [3:0]                        wr_row,
  input  logic [3:0]                        wr_col,
  input  logic                              wr_mode,
  input  logic                              wr_bcast,
  input  logic [PCKG_SZ-18:0]               wr_payload,
  output logic                              wr_ready,
  output logic [PCKG_SZ-1:0]                data_out_i_in,
  output logic                              pndng_i_in,
  input  logic                              popin,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   occupancy,
  output logic [15:0]                       ovf_cnt,
  output logic [7:0]                        bad_dest_cnt
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [PCKG_SZ-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr_reg, wr_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [15:0]        ovf_cnt_reg;
  logic [7:0]         bad_dest_cnt_reg;

  logic               legal_dest;
  logic               full, empty;
  logic               do_push, do_pop;
  logic               drop_ovf, drop_bad;
  logic [3:0]         pkt_row, pkt_col;
  logic [PCKG_SZ-1:0] pkt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  // Broadcast bypasses the coordinate range check entirely.
  assign legal_dest = wr_bcast ||
                      ((32'(wr_row) < 32'(ROWS)) && (32'(wr_col) < 32'(COLUMS)));
  assign full       = (count_reg == CNT_W'(FIFO_DEPTH));
  assign empty      = (count_reg == '0);
  assign do_pop     = popin && !empty;
  // A full queue still takes a write when the head leaves in the same cycle.
  assign do_push    = wr_en && legal_dest && (!full || popin);
  assign drop_ovf   = wr_en && legal_dest && !do_push;
  assign drop_bad   = wr_en && !legal_dest;

  assign pkt_row = wr_bcast ? 4'hF : wr_row;
  assign pkt_col = wr_bcast ? 4'hF : wr_col;
  assign pkt     = {8'h00, pkt_row, pkt_col, wr_mode, wr_payload};

  // Storage has no reset: emptiness is tracked by count_reg, and the head
  // output is forced to zero when empty.
  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (do_push && (wr_ptr_reg == PTR_W'(gi))) mem[gi] <= pkt;
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_reg       <= '0;
      wr_ptr_reg       <= '0;
      count_reg        <= '0;
      ovf_cnt_reg      <= '0;
      bad_dest_cnt_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
      if (drop_ovf && (ovf_cnt_reg != 16'hFFFF))
        ovf_cnt_reg <= ovf_cnt_reg + 16'd1;
      if (drop_bad && (bad_dest_cnt_reg != 8'hFF))
        bad_dest_cnt_reg <= bad_dest_cnt_reg + 8'd1;
    end
  end

  // FWFT: head comes straight from storage, no output register.
  assign data_out_i_in = empty ? '0 : mem[rd_ptr_reg];
  assign pndng_i_in    = !empty;
  assign wr_ready      = !full;
  assign occupancy     = count_reg;
  assign ovf_cnt       = ovf_cnt_reg;
  assign bad_dest_cnt  = bad_dest_cnt_reg;

endmodule

// File: tb/tb_mesh_term_inject.sv
module tb_mesh_term_inject;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en, wr_mode, wr_bcast, popin;
  logic [3:0]  wr_row, wr_col;
  logic [22:0] wr_payload;
  logic        wr_ready, pndng_i_in;
  logic [39:0] data_out_i_in;
  logic [2:0]  occupancy;
  logic [15:0] ovf_cnt;
  logic [7:0]  bad_dest_cnt;

  int checks = 0;
  int failures = 0;

  // Scoreboard: expected queue contents plus model counters.
  logic [39:0] sb[$];
  logic [15:0] model_ovf;
  logic [7:0]  model_bad;
  logic        popped;
  logic [39:0] pop_seen, pop_exp;

  mesh_term_inject #(.ROWS(4), .COLUMS(4), .PCKG_SZ(40), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
    .wr_mode(wr_mode), .wr_bcast(wr_bcast), .wr_payload(wr_payload),
    .wr_ready(wr_ready), .data_out_i_in(data_out_i_in), .pndng_i_in(pndng_i_in),
    .popin(popin), .occupancy(occupancy), .ovf_cnt(ovf_cnt),
    .bad_dest_cnt(bad_dest_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [39:0] mk(input logic [3:0] r, input logic [3:0] c,
                                     input logic m, input logic [22:0] pl);
    return {8'h00, r, c, m, pl};
  endfunction

  // One clock cycle of stimulus; updates the scoreboard model at the edge.
  task automatic step(input logic w, input logic [3:0] r, input logic [3:0] c,
                      input logic m, input logic b, input logic [22:0] pl,
                      input logic p);
    logic legal, accept;
    logic [39:0] pkt;
    wr_en = w; wr_row = r; wr_col = c; wr_mode = m; wr_bcast = b;
    wr_payload = pl; popin = p;
    legal  = b || (r < 4'd4 && c < 4'd4);
    accept = w && legal && (sb.size() < 4 || p);
    pkt    = b ? mk(4'hF, 4'hF, m, pl) : mk(r, c, m, pl);
    popped = 1'b0;
    if (p && sb.size() > 0) begin
      popped   = 1'b1;
      pop_seen = data_out_i_in;
      pop_exp  = sb[0];
    end
    @(posedge clk);
    if (popped) void'(sb.pop_front());
    if (accept) sb.push_back(pkt);
    if (w && !legal && model_bad != 8'hFF) model_bad = model_bad + 8'd1;
    if (w && legal && !accept && model_ovf != 16'hFFFF) model_ovf = model_ovf + 16'd1;
    #1;
    wr_en = 0; wr_row = 0; wr_col = 0; wr_mode = 0; wr_bcast = 0;
    wr_payload = 0; popin = 0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    wr_en = 0; wr_row = 0; wr_col = 0; wr_mode = 0; wr_bcast = 0;
    wr_payload = 0; popin = 0;
    sb.delete(); model_ovf = 0; model_bad = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({pndng_i_in, data_out_i_in, wr_ready, occupancy} !== {1'b0, 40'h0, 1'b1, 3'd0}) begin
      failures++;
      $display("FAIL reset_outputs: got pndng=%b data=%h ready=%b occ=%0d want 0/0/1/0",
               pndng_i_in, data_out_i_in, wr_ready, occupancy);
    end
    checks++;
    if ({ovf_cnt, bad_dest_cnt} !== 24'h0) begin
      failures++;
      $display("FAIL reset_counters: got ovf=%h bad=%h want 0/0", ovf_cnt, bad_dest_cnt);
    end
    reset = 1'b0;
    #1;
    $display("reset done: occ=%0d ready=%b", occupancy, wr_ready);
  endtask

  task automatic test_single;
    step(1, 4'd1, 4'd2, 1'b1, 1'b0, 23'h000ABC, 0);
    checks++;
    if (pndng_i_in !== 1'b1 || data_out_i_in !== 40'h0012800ABC) begin
      failures++;
      $display("FAIL single_head: got pndng=%b data=%h want 1/0012800abc",
               pndng_i_in, data_out_i_in);
    end
    $display("single write: head=%h", data_out_i_in);
    step(0, 0, 0, 0, 0, 0, 1);
    checks++;
    if (pop_seen !== pop_exp) begin
      failures++;
      $display("FAIL single_pop: got %h want %h", pop_seen, pop_exp);
    end
    checks++;
    if (pndng_i_in !== 1'b0 || data_out_i_in !== 40'h0) begin
      failures++;
      $display("FAIL single_empty: got pndng=%b data=%h want 0/0", pndng_i_in, data_out_i_in);
    end
    $display("single pop: popped=%h", pop_seen);
  endtask

  task automatic test_fill_overflow;
    for (int i = 1; i <= 4; i++) step(1, 4'd3, 4'd0, 1'b0, 1'b0, 23'(i), 0);
    checks++;
    if (occupancy !== 3'd4 || wr_ready !== 1'b0) begin
      failures++;
      $display("FAIL fill_full: got occ=%0d ready=%b want 4/0", occupancy, wr_ready);
    end
    step(1, 4'd3, 4'd0, 1'b0, 1'b0, 23'd5, 0);
    checks++;
    if (ovf_cnt !== 16'd1 || occupancy !== 3'd4) begin
      failures++;
      $display("FAIL fill_ovf: got ovf=%0d occ=%0d want 1/4", ovf_cnt, occupancy);
    end
    $display("overflow write: ovf=%0d", ovf_cnt);
    for (int i = 1; i <= 4; i++) begin
      step(0, 0, 0, 0, 0, 0, 1);
      checks++;
      if (pop_seen !== pop_exp || pop_seen[22:0] !== 23'(i)) begin
        failures++;
        $display("FAIL fill_drain%0d: got %h want %h", i, pop_seen, pop_exp);
      end
      $display("drain %0d: payload=%0d", i, pop_seen[22:0]);
    end
  endtask

  task automatic test_full_push_pop;
    logic [22:0] order [4];
    order[0] = 23'd2; order[1] = 23'd3; order[2] = 23'd4; order[3] = 23'd9;
    for (int i = 1; i <= 4; i++) step(1, 4'd0, 4'd3, 1'b1, 1'b0, 23'(i), 0);
    step(1, 4'd0, 4'd3, 1'b1, 1'b0, 23'd9, 1);
    checks++;
    if (pop_seen !== pop_exp) begin
      failures++;
      $display("FAIL fullpp_pop: got %h want %h", pop_seen, pop_exp);
    end
    checks++;
    if (ovf_cnt !== model_ovf || ovf_cnt !== 16'd1 || occupancy !== 3'd4) begin
      failures++;
      $display("FAIL fullpp_state: got ovf=%0d occ=%0d want 1/4", ovf_cnt, occupancy);
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 0, 1);
      checks++;
      if (pop_seen !== pop_exp || pop_seen[22:0] !== order[i]) begin
        failures++;
        $display("FAIL fullpp_drain%0d: got %h want payload %0d", i, pop_seen, order[i]);
      end
      $display("full push+pop drain %0d: payload=%0d", i, pop_seen[22:0]);
    end
  endtask

  task automatic test_bad_dest_bcast;
    step(1, 4'd4, 4'd0, 1'b0, 1'b0, 23'h11, 0);
    checks++;
    if (bad_dest_cnt !== 8'd1 || occupancy !== 3'd0 || ovf_cnt !== model_ovf) begin
      failures++;
      $display("FAIL bad_dest: got bad=%0d occ=%0d ovf=%0d want 1/0/%0d",
               bad_dest_cnt, occupancy, ovf_cnt, model_ovf);
    end
    step(1, 4'd7, 4'd9, 1'b0, 1'b1, 23'h22, 0);
    checks++;
    if (occupancy !== 3'd1 || data_out_i_in !== 40'h00FF000022) begin
      failures++;
      $display("FAIL bcast_head: got occ=%0d data=%h want 1/00ff000022", occupancy, data_out_i_in);
    end
    $display("bcast write: head=%h bad=%0d", data_out_i_in, bad_dest_cnt);
    step(0, 0, 0, 0, 0, 0, 1);
    checks++;
    if (pop_seen !== pop_exp) begin
      failures++;
      $display("FAIL bcast_pop: got %h want %h", pop_seen, pop_exp);
    end
  endtask

  task automatic test_empty_pop_and_async_reset;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0, 1);
      checks++;
      if (occupancy !== 3'd0 || pndng_i_in !== 1'b0) begin
        failures++;
        $display("FAIL empty_pop%0d: got occ=%0d pndng=%b want 0/0", i, occupancy, pndng_i_in);
      end
    end
    for (int i = 0; i < 3; i++) step(1, 4'd2, 4'd2, 1'b0, 1'b0, 23'(40 + i), 0);
    checks++;
    if (occupancy !== 3'd3) begin
      failures++;
      $display("FAIL prereset_occ: got %0d want 3", occupancy);
    end
    // Assert reset between edges and look before any rising edge arrives.
    #2 reset = 1'b1;
    #1;
    sb.delete(); model_ovf = 0; model_bad = 0;
    checks++;
    if ({pndng_i_in, data_out_i_in, wr_ready, occupancy, ovf_cnt, bad_dest_cnt} !==
        {1'b0, 40'h0, 1'b1, 3'd0, 16'h0, 8'h0}) begin
      failures++;
      $display("FAIL async_reset: got pndng=%b data=%h ready=%b occ=%0d ovf=%0d bad=%0d",
               pndng_i_in, data_out_i_in, wr_ready, occupancy, ovf_cnt, bad_dest_cnt);
    end
    $display("async reset: occ=%0d pndng=%b", occupancy, pndng_i_in);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 4; i++) step(1, 4'd1, 4'd1, 1'b0, 1'b0, 23'(i), 0);
    for (int i = 0; i < 70000; i++) step(1, 4'd1, 4'd1, 1'b0, 1'b0, 23'h7F, 0);
    checks++;
    if (ovf_cnt !== 16'hFFFF || ovf_cnt !== model_ovf) begin
      failures++;
      $display("FAIL ovf_saturate: got %h want ffff", ovf_cnt);
    end
    for (int i = 0; i < 300; i++) step(1, 4'd0, 4'd5, 1'b0, 1'b0, 23'h1, 0);
    checks++;
    if (bad_dest_cnt !== 8'hFF || bad_dest_cnt !== model_bad || occupancy !== 3'd4) begin
      failures++;
      $display("FAIL bad_saturate: got bad=%h occ=%0d want ff/4", bad_dest_cnt, occupancy);
    end
    $display("saturation: ovf=%h bad=%h", ovf_cnt, bad_dest_cnt);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 0, 1);
      checks++;
      if (pop_seen !== pop_exp || pop_seen[22:0] !== 23'(i)) begin
        failures++;
        $display("FAIL sat_drain%0d: got %h want %h", i, pop_seen, pop_exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_full_push_pop();
    test_bad_dest_bcast();
    test_empty_pop_and_async_reset();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
